// File: rtl/accum_pkg.sv
// Shared types and saturation helpers for the frame accumulator.
package accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int MAXW = 64;

  function automatic logic [MAXW-1:0] sat_max(input int n);
    return (MAXW'(1) << (n - 1)) - MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] sat_min(input int n);
    return MAXW'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/accum_frame_n_if.sv
// Sample input and frame result bundle for accum_frame_n.
interface accum_frame_n_if #(
  parameter int N   = 8,
  parameter int LEN = 16
);
  localparam int CW = $clog2(LEN + 1);

  logic          start;
  logic          in_valid;
  logic [N-1:0]  data;
  logic          sub;
  logic          sat;
  logic [N-1:0]  acc;
  logic          carry;
  logic          overflow;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid, data, sub, sat,
    input  acc, carry, overflow, count, busy, done
  );

  modport slave (
    input  start, in_valid, data, sub, sat,
    output acc, carry, overflow, count, busy, done
  );

endinterface

// File: rtl/add_sub_n.sv
// Ripple add/subtract built from a full_adder chain, with
// carry-out and signed-overflow flags.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_sub_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);
  logic [N-1:0] be;
  logic [N:0]   c;

  // Subtract as a + ~b + 1
  assign be   = b ^ {N{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (be[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[N];
  assign ovf  = (a[N-1] == be[N-1]) && (s[N-1] != a[N-1]);

endmodule

// File: rtl/accum_frame_n.sv
// Frame-based signed accumulator: LEN samples per frame,
// add/sub, wrap/saturate, sticky overflow, done pulse.
module accum_frame_n
  import accum_pkg::*;
#(
  parameter int N   = 8,
  parameter int LEN = 16
) (
  input  logic          clk,
  input  logic          aclr,
  accum_frame_n_if.slave bus
);
  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic [N-1:0]  SMAX = N'(sat_max(N));
  localparam logic [N-1:0]  SMIN = N'(sat_min(N));

  state_e        st_q, st_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          take;

  add_sub_n #(.N(N)) u_as (
    .a    (acc_q),
    .b    (bus.data),
    .sub  (bus.sub),
    .s    (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // Restart wins over a coincident sample
  assign take = (st_q == ST_RUN) && bus.in_valid && !bus.start;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: if (bus.start) st_d = ST_RUN;
      ST_RUN:  if (take && cnt_q == LAST) st_d = ST_DONE;
      ST_DONE: st_d = bus.start ? ST_RUN : ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      bus.start: begin
        acc_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end
      take: begin
        if (bus.sat && ovf) acc_d = acc_q[N-1] ? SMIN : SMAX;
        else                acc_d = sum;
        carry_d = cout;
        ovf_d   = ovf_q | ovf;
        cnt_d   = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.acc      = acc_q;
    bus.carry    = carry_q;
    bus.overflow = ovf_q;
    bus.count    = cnt_q;
    bus.busy     = (st_q == ST_RUN);
    bus.done     = (st_q == ST_DONE);
  end

endmodule

// File: tb/tb_accum_frame_n.sv
// Directed self-checking bench for accum_frame_n (N=8, LEN=4).
module tb_accum_frame_n;

  logic clk;
  logic aclr;
  int   errs;
  int   checks;

  accum_frame_n_if #(.N(8), .LEN(4)) bus ();

  accum_frame_n #(.N(8), .LEN(4)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic put(input logic [7:0] d,
                     input logic s,
                     input logic t);
    bus.in_valid = 1'b1;
    bus.data     = d;
    bus.sub      = s;
    bus.sat      = t;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    errs         = 0;
    checks       = 0;
    aclr         = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.data     = '0;
    bus.sub      = 1'b0;
    bus.sat      = 1'b0;

    #2;
    check("rst_acc",   32'(bus.acc), 32'h0);
    check("rst_carry", 32'(bus.carry), 32'h0);
    check("rst_ovf",   32'(bus.overflow), 32'h0);
    check("rst_cnt",   32'(bus.count), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    check("rst_done",  32'(bus.done), 32'h0);
    #10;
    aclr = 1'b1;
    tick();

    // Wrap add
    go();
    check("wa_busy", 32'(bus.busy), 32'h1);
    put(8'h10, 1'b0, 1'b0);
    put(8'h20, 1'b0, 1'b0);
    put(8'h30, 1'b0, 1'b0);
    check("wa_acc3",  32'(bus.acc), 32'h60);
    check("wa_cnt3",  32'(bus.count), 32'h3);
    check("wa_done3", 32'(bus.done), 32'h0);
    put(8'h40, 1'b0, 1'b0);
    check("wa_acc",   32'(bus.acc), 32'hA0);
    check("wa_ovf",   32'(bus.overflow), 32'h1);
    check("wa_carry", 32'(bus.carry), 32'h0);
    check("wa_cnt",   32'(bus.count), 32'h4);
    check("wa_done",  32'(bus.done), 32'h1);
    check("wa_busy4", 32'(bus.busy), 32'h0);
    tick();
    check("wa_done_off", 32'(bus.done), 32'h0);
    check("wa_hold",     32'(bus.acc), 32'hA0);
    put(8'h09, 1'b0, 1'b0);
    check("idle_acc", 32'(bus.acc), 32'hA0);
    check("idle_cnt", 32'(bus.count), 32'h4);

    // Saturating add
    go();
    check("sa_clr", 32'(bus.acc), 32'h0);
    put(8'h10, 1'b0, 1'b1);
    put(8'h20, 1'b0, 1'b1);
    put(8'h30, 1'b0, 1'b1);
    put(8'h40, 1'b0, 1'b1);
    check("sa_acc",   32'(bus.acc), 32'h7F);
    check("sa_ovf",   32'(bus.overflow), 32'h1);
    check("sa_carry", 32'(bus.carry), 32'h0);
    check("sa_done",  32'(bus.done), 32'h1);
    tick();

    // Subtract: last step 0xFD-1 has no borrow
    go();
    for (int i = 0; i < 4; i++) put(8'h01, 1'b1, 1'b1);
    check("sb_acc",   32'(bus.acc), 32'hFC);
    check("sb_ovf",   32'(bus.overflow), 32'h0);
    check("sb_carry", 32'(bus.carry), 32'h1);
    tick();
    go();
    put(8'h70, 1'b1, 1'b1);
    check("sn_acc1", 32'(bus.acc), 32'h90);
    check("sn_ovf1", 32'(bus.overflow), 32'h0);
    put(8'h70, 1'b1, 1'b1);
    check("sn_acc2", 32'(bus.acc), 32'h80);
    put(8'h00, 1'b1, 1'b1);
    put(8'h00, 1'b1, 1'b1);
    check("sn_acc", 32'(bus.acc), 32'h80);
    check("sn_ovf", 32'(bus.overflow), 32'h1);
    check("sn_done", 32'(bus.done), 32'h1);
    tick();

    // Gaps and restart
    go();
    put(8'h05, 1'b0, 1'b0);
    tick();
    tick();
    put(8'h05, 1'b0, 1'b0);
    check("gp_cnt", 32'(bus.count), 32'h2);
    check("gp_acc", 32'(bus.acc), 32'h0A);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.data     = 8'h05;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("rs_acc",  32'(bus.acc), 32'h0);
    check("rs_cnt",  32'(bus.count), 32'h0);
    check("rs_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 3; i++) put(8'h01, 1'b0, 1'b0);
    check("rs_done3", 32'(bus.done), 32'h0);
    put(8'h01, 1'b0, 1'b0);
    check("rs_acc4", 32'(bus.acc), 32'h04);
    check("rs_done", 32'(bus.done), 32'h1);
    tick();
    check("rs_done_off", 32'(bus.done), 32'h0);

    // Start during DONE
    go();
    for (int i = 0; i < 4; i++) put(8'h01, 1'b0, 1'b0);
    check("sd_done", 32'(bus.done), 32'h1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("sd_acc",  32'(bus.acc), 32'h0);
    check("sd_cnt",  32'(bus.count), 32'h0);
    check("sd_busy", 32'(bus.busy), 32'h1);
    check("sd_done_off", 32'(bus.done), 32'h0);

    // Reset mid-frame
    put(8'h70, 1'b0, 1'b0);
    put(8'h70, 1'b0, 1'b0);
    check("mr_acc_pre", 32'(bus.acc), 32'hE0);
    check("mr_ovf_pre", 32'(bus.overflow), 32'h1);
    aclr = 1'b0;
    #1;
    check("mr_acc",  32'(bus.acc), 32'h0);
    check("mr_cnt",  32'(bus.count), 32'h0);
    check("mr_busy", 32'(bus.busy), 32'h0);
    check("mr_ovf",  32'(bus.overflow), 32'h0);
    #2;
    aclr = 1'b1;
    tick();
    go();
    for (int i = 0; i < 4; i++) put(8'h02, 1'b0, 1'b0);
    check("nf_acc",  32'(bus.acc), 32'h08);
    check("nf_ovf",  32'(bus.overflow), 32'h0);
    check("nf_done", 32'(bus.done), 32'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
